aes_key_expansion: RTL and testbench

- Iterative AES-128 key schedule. It sits directly upstream of the round-key XOR stage.
- Accepts a 128-bit cipher key on a start pulse and computes the round keys for rounds 0..10, one round key per cycle.
- Presents all eleven round keys as one flat 1408-bit bus, held stable for the consuming stage, which selects one slice per round count.

---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_sbox.sv | 46 ++++
 rtl/aes_key_expansion.sv | 119 +++++++++++
 tb/tb_aes_key_expansion.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and types.
// Holds the key-schedule widths, the Rcon table, the 32-bit word type and
// the key-schedule FSM state encoding.
package aes_pkg;

    localparam int unsigned KEY_W      = 128;
    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned RK_BUS_W   = KEY_W * (NUM_ROUNDS + 1);
    localparam int unsigned RND_W      = 4;

    // Rcon indexed by round number 1..10; unused entries are padded with zero
    // so that any RND_W-bit index stays in range.
    localparam logic [15:0][7:0] RCON = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
        8'h00
    };

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational byte substitution.
// Ports: data - input byte; sub_c - substituted byte.
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] sub_c
);

    always_comb begin
        sub_c = 8'h00;
        case (data)
            8'h00: sub_c = 8'h63; 8'h01: sub_c = 8'h7c; 8'h02: sub_c = 8'h77; 8'h03: sub_c = 8'h7b; 8'h04: sub_c = 8'hf2; 8'h05: sub_c = 8'h6b; 8'h06: sub_c = 8'h6f; 8'h07: sub_c = 8'hc5;
            8'h08: sub_c = 8'h30; 8'h09: sub_c = 8'h01; 8'h0a: sub_c = 8'h67; 8'h0b: sub_c = 8'h2b; 8'h0c: sub_c = 8'hfe; 8'h0d: sub_c = 8'hd7; 8'h0e: sub_c = 8'hab; 8'h0f: sub_c = 8'h76;
            8'h10: sub_c = 8'hca; 8'h11: sub_c = 8'h82; 8'h12: sub_c = 8'hc9; 8'h13: sub_c = 8'h7d; 8'h14: sub_c = 8'hfa; 8'h15: sub_c = 8'h59; 8'h16: sub_c = 8'h47; 8'h17: sub_c = 8'hf0;
            8'h18: sub_c = 8'had; 8'h19: sub_c = 8'hd4; 8'h1a: sub_c = 8'ha2; 8'h1b: sub_c = 8'haf; 8'h1c: sub_c = 8'h9c; 8'h1d: sub_c = 8'ha4; 8'h1e: sub_c = 8'h72; 8'h1f: sub_c = 8'hc0;
            8'h20: sub_c = 8'hb7; 8'h21: sub_c = 8'hfd; 8'h22: sub_c = 8'h93; 8'h23: sub_c = 8'h26; 8'h24: sub_c = 8'h36; 8'h25: sub_c = 8'h3f; 8'h26: sub_c = 8'hf7; 8'h27: sub_c = 8'hcc;
            8'h28: sub_c = 8'h34; 8'h29: sub_c = 8'ha5; 8'h2a: sub_c = 8'he5; 8'h2b: sub_c = 8'hf1; 8'h2c: sub_c = 8'h71; 8'h2d: sub_c = 8'hd8; 8'h2e: sub_c = 8'h31; 8'h2f: sub_c = 8'h15;
            8'h30: sub_c = 8'h04; 8'h31: sub_c = 8'hc7; 8'h32: sub_c = 8'h23; 8'h33: sub_c = 8'hc3; 8'h34: sub_c = 8'h18; 8'h35: sub_c = 8'h96; 8'h36: sub_c = 8'h05; 8'h37: sub_c = 8'h9a;
            8'h38: sub_c = 8'h07; 8'h39: sub_c = 8'h12; 8'h3a: sub_c = 8'h80; 8'h3b: sub_c = 8'he2; 8'h3c: sub_c = 8'heb; 8'h3d: sub_c = 8'h27; 8'h3e: sub_c = 8'hb2; 8'h3f: sub_c = 8'h75;
            8'h40: sub_c = 8'h09; 8'h41: sub_c = 8'h83; 8'h42: sub_c = 8'h2c; 8'h43: sub_c = 8'h1a; 8'h44: sub_c = 8'h1b; 8'h45: sub_c = 8'h6e; 8'h46: sub_c = 8'h5a; 8'h47: sub_c = 8'ha0;
            8'h48: sub_c = 8'h52; 8'h49: sub_c = 8'h3b; 8'h4a: sub_c = 8'hd6; 8'h4b: sub_c = 8'hb3; 8'h4c: sub_c = 8'h29; 8'h4d: sub_c = 8'he3; 8'h4e: sub_c = 8'h2f; 8'h4f: sub_c = 8'h84;
            8'h50: sub_c = 8'h53; 8'h51: sub_c = 8'hd1; 8'h52: sub_c = 8'h00; 8'h53: sub_c = 8'hed; 8'h54: sub_c = 8'h20; 8'h55: sub_c = 8'hfc; 8'h56: sub_c = 8'hb1; 8'h57: sub_c = 8'h5b;
            8'h58: sub_c = 8'h6a; 8'h59: sub_c = 8'hcb; 8'h5a: sub_c = 8'hbe; 8'h5b: sub_c = 8'h39; 8'h5c: sub_c = 8'h4a; 8'h5d: sub_c = 8'h4c; 8'h5e: sub_c = 8'h58; 8'h5f: sub_c = 8'hcf;
            8'h60: sub_c = 8'hd0; 8'h61: sub_c = 8'hef; 8'h62: sub_c = 8'haa; 8'h63: sub_c = 8'hfb; 8'h64: sub_c = 8'h43; 8'h65: sub_c = 8'h4d; 8'h66: sub_c = 8'h33; 8'h67: sub_c = 8'h85;
            8'h68: sub_c = 8'h45; 8'h69: sub_c = 8'hf9; 8'h6a: sub_c = 8'h02; 8'h6b: sub_c = 8'h7f; 8'h6c: sub_c = 8'h50; 8'h6d: sub_c = 8'h3c; 8'h6e: sub_c = 8'h9f; 8'h6f: sub_c = 8'ha8;
            8'h70: sub_c = 8'h51; 8'h71: sub_c = 8'ha3; 8'h72: sub_c = 8'h40; 8'h73: sub_c = 8'h8f; 8'h74: sub_c = 8'h92; 8'h75: sub_c = 8'h9d; 8'h76: sub_c = 8'h38; 8'h77: sub_c = 8'hf5;
            8'h78: sub_c = 8'hbc; 8'h79: sub_c = 8'hb6; 8'h7a: sub_c = 8'hda; 8'h7b: sub_c = 8'h21; 8'h7c: sub_c = 8'h10; 8'h7d: sub_c = 8'hff; 8'h7e: sub_c = 8'hf3; 8'h7f: sub_c = 8'hd2;
            8'h80: sub_c = 8'hcd; 8'h81: sub_c = 8'h0c; 8'h82: sub_c = 8'h13; 8'h83: sub_c = 8'hec; 8'h84: sub_c = 8'h5f; 8'h85: sub_c = 8'h97; 8'h86: sub_c = 8'h44; 8'h87: sub_c = 8'h17;
            8'h88: sub_c = 8'hc4; 8'h89: sub_c = 8'ha7; 8'h8a: sub_c = 8'h7e; 8'h8b: sub_c = 8'h3d; 8'h8c: sub_c = 8'h64; 8'h8d: sub_c = 8'h5d; 8'h8e: sub_c = 8'h19; 8'h8f: sub_c = 8'h73;
            8'h90: sub_c = 8'h60; 8'h91: sub_c = 8'h81; 8'h92: sub_c = 8'h4f; 8'h93: sub_c = 8'hdc; 8'h94: sub_c = 8'h22; 8'h95: sub_c = 8'h2a; 8'h96: sub_c = 8'h90; 8'h97: sub_c = 8'h88;
            8'h98: sub_c = 8'h46; 8'h99: sub_c = 8'hee; 8'h9a: sub_c = 8'hb8; 8'h9b: sub_c = 8'h14; 8'h9c: sub_c = 8'hde; 8'h9d: sub_c = 8'h5e; 8'h9e: sub_c = 8'h0b; 8'h9f: sub_c = 8'hdb;
            8'ha0: sub_c = 8'he0; 8'ha1: sub_c = 8'h32; 8'ha2: sub_c = 8'h3a; 8'ha3: sub_c = 8'h0a; 8'ha4: sub_c = 8'h49; 8'ha5: sub_c = 8'h06; 8'ha6: sub_c = 8'h24; 8'ha7: sub_c = 8'h5c;
            8'ha8: sub_c = 8'hc2; 8'ha9: sub_c = 8'hd3; 8'haa: sub_c = 8'hac; 8'hab: sub_c = 8'h62; 8'hac: sub_c = 8'h91; 8'had: sub_c = 8'h95; 8'hae: sub_c = 8'he4; 8'haf: sub_c = 8'h79;
            8'hb0: sub_c = 8'he7; 8'hb1: sub_c = 8'hc8; 8'hb2: sub_c = 8'h37; 8'hb3: sub_c = 8'h6d; 8'hb4: sub_c = 8'h8d; 8'hb5: sub_c = 8'hd5; 8'hb6: sub_c = 8'h4e; 8'hb7: sub_c = 8'ha9;
            8'hb8: sub_c = 8'h6c; 8'hb9: sub_c = 8'h56; 8'hba: sub_c = 8'hf4; 8'hbb: sub_c = 8'hea; 8'hbc: sub_c = 8'h65; 8'hbd: sub_c = 8'h7a; 8'hbe: sub_c = 8'hae; 8'hbf: sub_c = 8'h08;
            8'hc0: sub_c = 8'hba; 8'hc1: sub_c = 8'h78; 8'hc2: sub_c = 8'h25; 8'hc3: sub_c = 8'h2e; 8'hc4: sub_c = 8'h1c; 8'hc5: sub_c = 8'ha6; 8'hc6: sub_c = 8'hb4; 8'hc7: sub_c = 8'hc6;
            8'hc8: sub_c = 8'he8; 8'hc9: sub_c = 8'hdd; 8'hca: sub_c = 8'h74; 8'hcb: sub_c = 8'h1f; 8'hcc: sub_c = 8'h4b; 8'hcd: sub_c = 8'hbd; 8'hce: sub_c = 8'h8b; 8'hcf: sub_c = 8'h8a;
            8'hd0: sub_c = 8'h70; 8'hd1: sub_c = 8'h3e; 8'hd2: sub_c = 8'hb5; 8'hd3: sub_c = 8'h66; 8'hd4: sub_c = 8'h48; 8'hd5: sub_c = 8'h03; 8'hd6: sub_c = 8'hf6; 8'hd7: sub_c = 8'h0e;
            8'hd8: sub_c = 8'h61; 8'hd9: sub_c = 8'h35; 8'hda: sub_c = 8'h57; 8'hdb: sub_c = 8'hb9; 8'hdc: sub_c = 8'h86; 8'hdd: sub_c = 8'hc1; 8'hde: sub_c = 8'h1d; 8'hdf: sub_c = 8'h9e;
            8'he0: sub_c = 8'he1; 8'he1: sub_c = 8'hf8; 8'he2: sub_c = 8'h98; 8'he3: sub_c = 8'h11; 8'he4: sub_c = 8'h69; 8'he5: sub_c = 8'hd9; 8'he6: sub_c = 8'h8e; 8'he7: sub_c = 8'h94;
            8'he8: sub_c = 8'h9b; 8'he9: sub_c = 8'h1e; 8'hea: sub_c = 8'h87; 8'heb: sub_c = 8'he9; 8'hec: sub_c = 8'hce; 8'hed: sub_c = 8'h55; 8'hee: sub_c = 8'h28; 8'hef: sub_c = 8'hdf;
            8'hf0: sub_c = 8'h8c; 8'hf1: sub_c = 8'ha1; 8'hf2: sub_c = 8'h89; 8'hf3: sub_c = 8'h0d; 8'hf4: sub_c = 8'hbf; 8'hf5: sub_c = 8'he6; 8'hf6: sub_c = 8'h42; 8'hf7: sub_c = 8'h68;
            8'hf8: sub_c = 8'h41; 8'hf9: sub_c = 8'h99; 8'hfa: sub_c = 8'h2d; 8'hfb: sub_c = 8'h0f; 8'hfc: sub_c = 8'hb0; 8'hfd: sub_c = 8'h54; 8'hfe: sub_c = 8'hbb; 8'hff: sub_c = 8'h16;
        endcase
    end

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per cycle into a flat bus.
// Ports: clk, rst (async, active-high); start/cipher_key request an expansion;
// busy while rounds 1..10 are produced; keys_valid while round_keys holds a
// complete schedule; round_keys carries round key i at [128*i +: 128].
module aes_key_expansion
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_W-1:0]    cipher_key,
    output logic                busy,
    output logic                keys_valid,
    output logic [RK_BUS_W-1:0] round_keys
);

    ks_state_t        state, state_d;
    logic [RND_W-1:0] rnd, rnd_d;
    logic             busy_d, keys_valid_d;
    logic             load_c, write_c;

    logic [KEY_W-1:0] work;
    logic [KEY_W-1:0] next_key_c;
    word_t            rot_c, sub_c, temp_c;
    word_t            w0, w1, w2, w3;
    word_t            n0, n1, n2, n3;

    // Round function on the working register (w0 in the top word).
    assign w0    = work[127:96];
    assign w1    = work[95:64];
    assign w2    = work[63:32];
    assign w3    = work[31:0];
    assign rot_c = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .data  (rot_c[8*i +: 8]),
            .sub_c (sub_c[8*i +: 8])
        );
    end

    assign temp_c     = sub_c ^ {RCON[rnd], 24'h000000};
    assign n0         = w0 ^ temp_c;
    assign n1         = w1 ^ n0;
    assign n2         = w2 ^ n1;
    assign n3         = w3 ^ n2;
    assign next_key_c = {n0, n1, n2, n3};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d      = state;
        rnd_d        = rnd;
        busy_d       = busy;
        keys_valid_d = keys_valid;
        load_c       = 1'b0;
        write_c      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c       = 1'b1;
                    rnd_d        = RND_W'(1);
                    busy_d       = 1'b1;
                    keys_valid_d = 1'b0;
                    state_d      = EXPAND;
                end
            end
            EXPAND: begin
                write_c = 1'b1;
                if (rnd == RND_W'(NUM_ROUNDS)) begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    rnd_d = rnd + RND_W'(1);
                end
            end
            DONE: begin
                keys_valid_d = 1'b1;
                rnd_d        = '0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; only the addressed slice is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd        <= '0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            work       <= '0;
            round_keys <= '0;
        end else begin
            rnd        <= rnd_d;
            busy       <= busy_d;
            keys_valid <= keys_valid_d;
            if (load_c) begin
                work                <= cipher_key;
                round_keys[0 +: KEY_W] <= cipher_key;
            end
            if (write_c) begin
                work                             <= next_key_c;
                round_keys[KEY_W*rnd +: KEY_W]   <= next_key_c;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed self-checking bench for aes_key_expansion with a slice scoreboard.
module tb_aes_key_expansion;

    logic           clk;
    logic           rst;
    logic           start;
    logic [127:0]   cipher_key;
    logic           busy;
    logic           keys_valid;
    logic [1407:0]  round_keys;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string        name;
        int           idx;
        logic [127:0] val;
    } exp_t;

    exp_t sb[$];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_S1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_S10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ZERO_S1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_S10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_expansion dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cipher_key (cipher_key),
        .busy       (busy),
        .keys_valid (keys_valid),
        .round_keys (round_keys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start an expansion and follow it to keys_valid; optional re-pulses of
    // start land on edges rp_a / rp_b (counted from the accepting edge 0).
    task automatic run_exp(input string name, input logic [127:0] key,
                           input logic [127:0] s1, input logic [127:0] s10,
                           input logic kv_before, input int rp_a, input int rp_b);
        int busy_cnt;
        int kv_edge;
        sb.push_back('{name, 0, key});
        sb.push_back('{name, 1, s1});
        sb.push_back('{name, 10, s10});
        chk({name, "_kv_before"}, 128'(keys_valid), 128'(kv_before));
        start      = 1'b1;
        cipher_key = key;
        @(posedge clk); #1;
        start      = 1'b0;
        cipher_key = ~key;
        chk({name, "_kv_drop"}, 128'(keys_valid), 128'(1'b0));
        chk({name, "_slice0_edge0"}, round_keys[127:0], key);
        busy_cnt = busy ? 1 : 0;
        kv_edge  = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n == rp_a || n == rp_b) begin
                start      = 1'b1;
                cipher_key = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (n == 1) chk({name, "_slice1_edge1"}, round_keys[255:128], s1);
            if (busy) busy_cnt++;
            if (keys_valid) begin
                kv_edge = n;
                break;
            end
        end
        chk({name, "_kv_edge"}, 128'(kv_edge), 128'(11));
        chk({name, "_busy_cycles"}, 128'(busy_cnt), 128'(10));
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("%s_slice%0d", e.name, e.idx), round_keys[128*e.idx +: 128], e.val);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cipher_key = '0;
        #1;
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_kv", 128'(keys_valid), 128'(1'b0));
        chk("rst_rk_zero", 128'(round_keys == '0), 128'(1'b1));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_exp("fips", FIPS_KEY, FIPS_S1, FIPS_S10, 1'b0, -1, -1);

        // Back-to-back with the all-zero key.
        run_exp("zero_b2b", ZERO_KEY, ZERO_S1, ZERO_S10, 1'b1, -1, -1);

        // Re-pulsed start mid-expansion and on the last write edge.
        run_exp("repulse", FIPS_KEY, FIPS_S1, FIPS_S10, 1'b1, 3, 10);

        // Hold result stable a few idle cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_kv", 128'(keys_valid), 128'(1'b1));
        chk("hold_slice10", round_keys[1407:1280], FIPS_S10);

        // Reset in the middle of an expansion.
        start      = 1'b1;
        cipher_key = ZERO_KEY;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy), 128'(1'b0));
        chk("midrst_kv", 128'(keys_valid), 128'(1'b0));
        chk("midrst_rk_zero", 128'(round_keys == '0), 128'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_kv", 128'(keys_valid), 128'(1'b0));

        run_exp("fips_after_rst", FIPS_KEY, FIPS_S1, FIPS_S10, 1'b0, -1, -1);
        run_exp("zero_again", ZERO_KEY, ZERO_S1, ZERO_S10, 1'b1, -1, -1);
        chk("zero_slice0", round_keys[127:0], 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
